// File: rtl/gray_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : gray_pkg                                               |
// | Description : Shared Gray-code helpers and counter mode constants.   |
// |               The functions work on 32-bit zero-extended values, so  |
// |               they are valid for any counter of up to 32 bits.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package gray_pkg;

  // Widest value the helper functions handle.
  localparam int MAX_WIDTH = 32;

  // End-of-range behaviour selectors for the SATURATE parameter.
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Binary to reflected Gray code. Zero extension does not change the low bits.
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray code to binary by prefix XOR from the MSB down. Zero upper bits
  // contribute nothing, so a narrower code decodes correctly.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage : gray_pkg
`default_nettype wire

// File: rtl/gray_to_bin.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : gray_to_bin                                            |
// | Description : Combinational Gray-to-binary decoder (prefix XOR from  |
// |               the MSB). Purely combinational, no clock or reset.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module gray_to_bin #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // The MSB passes straight through; each lower bit folds in everything above it.
  assign bin[WIDTH-1] = gray[WIDTH-1];

  generate
    for (genvar i = 0; i < WIDTH - 1; i++) begin : g_bit
      assign bin[i] = bin[i+1] ^ gray[i];
    end
  endgenerate

endmodule : gray_to_bin
`default_nettype wire

// File: rtl/gray_counter_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : gray_counter_param                                     |
// | Description : Parametrised up/down counter with Gray-coded output,   |
// |               Gray-coded parallel load, wrap or saturate at the ends,|
// |               sticky overflow/underflow flags and a terminal-count   |
// |               strobe for cascading. WIDTH must be at least 2.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module gray_counter_param
  import gray_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadGray,
  input  logic             ClrFlags,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Terminal
);

  localparam logic [WIDTH-1:0] c_max  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_zero = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam bit               c_sat  = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] r_cnt;
  logic             r_overflow;
  logic             r_underflow;

  logic [WIDTH-1:0] w_load_bin;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_up_step;
  logic             w_dn_step;
  logic             w_ovf_set;
  logic             w_unf_set;

  // Decode the Gray load value; the same decoder is reused by pointer synchronisers.
  gray_to_bin #(
    .WIDTH (WIDTH)
  ) u_load_dec (
    .gray (LoadGray),
    .bin  (w_load_bin)
  );

  // Step qualification: Load always masks a count step.
  assign w_at_max  = (r_cnt == c_max);
  assign w_at_zero = (r_cnt == c_zero);
  assign w_up_step = ~Load & En &  Dir;
  assign w_dn_step = ~Load & En & ~Dir;
  assign w_ovf_set = w_up_step & w_at_max;
  assign w_unf_set = w_dn_step & w_at_zero;

  // Count register: Reset > Load > En; ends either wrap or hold depending on mode.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt <= c_zero;
    end else if (Load) begin
      r_cnt <= w_load_bin;
    end else if (w_up_step) begin
      if (!w_at_max) begin
        r_cnt <= r_cnt + c_one;
      end else if (!c_sat) begin
        r_cnt <= c_zero;
      end
    end else if (w_dn_step) begin
      if (!w_at_zero) begin
        r_cnt <= r_cnt - c_one;
      end else if (!c_sat) begin
        r_cnt <= c_max;
      end
    end
  end

  // Sticky flags: a set in the same cycle as ClrFlags takes precedence.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (ClrFlags) begin
        r_overflow <= 1'b0;
      end
      if (w_unf_set) begin
        r_underflow <= 1'b1;
      end else if (ClrFlags) begin
        r_underflow <= 1'b0;
      end
    end
  end

  // Outputs: Gray code follows the count with no extra register stage.
  assign Binary    = r_cnt;
  assign Output    = r_cnt ^ (r_cnt >> 1);
  assign Overflow  = r_overflow;
  assign Underflow = r_underflow;

  // Pre-wrap strobe for cascading: high while the next step would cross an end.
  assign Terminal  = En & ~Load & (Dir ? w_at_max : w_at_zero);

endmodule : gray_counter_param
`default_nettype wire

// File: tb/tb_gray_counter_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_gray_counter_param                                  |
// | Description : Directed self-checking bench for gray_counter_param:   |
// |               3-bit wrap, 3-bit saturate and 8-bit instances.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_gray_counter_param;
  import gray_pkg::*;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Instance A: WIDTH=3, wrap
  logic       a_rst = 1'b0, a_en = 1'b0, a_dir = 1'b0, a_load = 1'b0, a_clr = 1'b0;
  logic [2:0] a_lg = 3'd0;
  logic [2:0] a_out, a_bin;
  logic       a_ovf, a_unf, a_term;

  // Instance B: WIDTH=3, saturate
  logic       b_rst = 1'b0, b_en = 1'b0, b_dir = 1'b0, b_load = 1'b0, b_clr = 1'b0;
  logic [2:0] b_lg = 3'd0;
  logic [2:0] b_out, b_bin;
  logic       b_ovf, b_unf, b_term;

  // Instance C: WIDTH=8, wrap
  logic       c_rst = 1'b0, c_en = 1'b0, c_dir = 1'b0, c_load = 1'b0, c_clr = 1'b0;
  logic [7:0] c_lg = 8'd0;
  logic [7:0] c_out, c_bin;
  logic       c_ovf, c_unf, c_term;

  gray_counter_param #(.WIDTH(3), .SATURATE(0)) u_a (
    .Clk(Clk), .Reset(a_rst), .En(a_en), .Dir(a_dir), .Load(a_load),
    .LoadGray(a_lg), .ClrFlags(a_clr), .Output(a_out), .Binary(a_bin),
    .Overflow(a_ovf), .Underflow(a_unf), .Terminal(a_term)
  );

  gray_counter_param #(.WIDTH(3), .SATURATE(1)) u_b (
    .Clk(Clk), .Reset(b_rst), .En(b_en), .Dir(b_dir), .Load(b_load),
    .LoadGray(b_lg), .ClrFlags(b_clr), .Output(b_out), .Binary(b_bin),
    .Overflow(b_ovf), .Underflow(b_unf), .Terminal(b_term)
  );

  gray_counter_param #(.WIDTH(8), .SATURATE(0)) u_c (
    .Clk(Clk), .Reset(c_rst), .En(c_en), .Dir(c_dir), .Load(c_load),
    .LoadGray(c_lg), .ClrFlags(c_clr), .Output(c_out), .Binary(c_bin),
    .Overflow(c_ovf), .Underflow(c_unf), .Terminal(c_term)
  );

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 3-bit Gray sequence indexed by binary count
  logic [2:0] g3 [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  logic [7:0]  prev_out;
  logic [7:0]  exp_bin;
  logic [31:0] exp_gray;

  initial begin
    // ---------------- Reset all instances ----------------
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_en = 1'b1; a_dir = 1'b1;   // reset must override a count request
    tick();
    check("A reset Output",    a_out, 3'b000);
    check("A reset Binary",    a_bin, 3'b000);
    check("A reset Overflow",  a_ovf, 1'b0);
    check("A reset Underflow", a_unf, 1'b0);
    check("B reset Output",    b_out, 3'b000);
    check("C reset Binary",    c_bin, 8'h00);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    #1;

    // ---------------- Test 1: 9 up-counts, wrap ----------------
    for (int k = 0; k < 9; k++) begin
      #1;
      check($sformatf("T1 Terminal k=%0d", k), a_term, (k % 8 == 7) ? 1'b1 : 1'b0);
      tick();
      check($sformatf("T1 Output k=%0d", k), a_out, g3[(k + 1) % 8]);
      check($sformatf("T1 Overflow k=%0d", k), a_ovf, (k >= 7) ? 1'b1 : 1'b0);
    end
    check("T1 final Binary", a_bin, 3'd1);

    // ---------------- Test 2: down through zero ----------------
    a_dir = 1'b0;
    tick();                               // 1 -> 0, no underflow
    check("T2 at zero Output", a_out, 3'b000);
    check("T2 at zero Underflow", a_unf, 1'b0);
    #1;
    check("T2 Terminal at zero", a_term, 1'b1);
    tick();                               // 0 -> 7
    check("T2 step1 Output", a_out, 3'b100);
    check("T2 step1 Underflow", a_unf, 1'b1);
    tick();                               // 7 -> 6
    check("T2 step2 Output", a_out, 3'b101);
    check("T2 step2 Underflow", a_unf, 1'b1);
    check("T2 Overflow unchanged", a_ovf, 1'b1);

    // ---------------- Test 5: clear flags, then set-wins ----------------
    a_en = 1'b0; a_clr = 1'b1;
    tick();
    check("T5 clr Overflow", a_ovf, 1'b0);
    check("T5 clr Underflow", a_unf, 1'b0);
    check("T5 clr keeps count", a_bin, 3'd6);
    a_clr = 1'b0; a_load = 1'b1; a_lg = 3'b100;   // Gray of MAX
    tick();
    check("T5 load MAX Binary", a_bin, 3'd7);
    a_load = 1'b0; a_clr = 1'b1; a_en = 1'b1; a_dir = 1'b1;
    #1;
    check("T5 Terminal at MAX", a_term, 1'b1);
    tick();
    check("T5 set wins Overflow", a_ovf, 1'b1);
    check("T5 wrap Binary", a_bin, 3'd0);
    a_clr = 1'b0;

    // ---------------- Test 4: load beats count ----------------
    a_load = 1'b1; a_lg = 3'b110; a_en = 1'b1; a_dir = 1'b0;
    #1;
    check("T4 Terminal masked by Load", a_term, 1'b0);
    tick();
    check("T4 load Binary", a_bin, 3'b100);
    check("T4 load Output", a_out, 3'b110);
    check("T4 load Overflow", a_ovf, 1'b1);
    check("T4 load Underflow", a_unf, 1'b0);
    a_load = 1'b0;
    tick();
    check("T4 after load Binary", a_bin, 3'b011);
    a_en = 1'b0;

    // ---------------- Test 3: saturate mode ----------------
    b_load = 1'b1; b_lg = 3'b100;
    tick();
    b_load = 1'b0; b_en = 1'b1; b_dir = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("T3 Terminal up k=%0d", k), b_term, 1'b1);
      tick();
      check($sformatf("T3 hold MAX Output k=%0d", k), b_out, 3'b100);
      check($sformatf("T3 Overflow k=%0d", k), b_ovf, 1'b1);
    end
    check("T3 Underflow untouched", b_unf, 1'b0);
    b_en = 1'b0; b_load = 1'b1; b_lg = 3'b000;
    tick();
    b_load = 1'b0; b_en = 1'b1; b_dir = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("T3 hold zero Output k=%0d", k), b_out, 3'b000);
      check($sformatf("T3 Underflow k=%0d", k), b_unf, 1'b1);
    end
    b_en = 1'b0;

    // ---------------- Test 6: 8-bit sweep, then mid-count reset ----------------
    prev_out = c_out;
    c_en = 1'b1; c_dir = 1'b1;
    for (int k = 0; k < 256; k++) begin
      tick();
      exp_bin  = 8'(k + 1);
      exp_gray = bin2gray({24'd0, exp_bin});
      check($sformatf("T6 sweep Binary k=%0d", k), c_bin, exp_bin);
      check($sformatf("T6 sweep Output k=%0d", k), c_out, exp_gray);
      check($sformatf("T6 sweep Hamming k=%0d", k), $countones(prev_out ^ c_out), 1);
      prev_out = c_out;
    end
    check("T6 sweep Overflow", c_ovf, 1'b1);
    c_en = 1'b0; c_load = 1'b1; c_lg = 8'h77;     // Gray of 0x5A
    tick();
    check("T6 load 0x5A Binary", c_bin, 8'h5A);
    c_load = 1'b0; c_en = 1'b1; c_dir = 1'b1; c_rst = 1'b1;
    tick();
    check("T6 reset Binary", c_bin, 8'h00);
    check("T6 reset Output", c_out, 8'h00);
    check("T6 reset Overflow", c_ovf, 1'b0);
    check("T6 reset Underflow", c_unf, 1'b0);
    c_rst = 1'b0; c_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_gray_counter_param
`default_nettype wire

// File: doc/gray_counter_param.md
Name: gray_counter_param

Overview:
- Parametrised Gray-code counter; next generation of the 3-bit fixed up-counter.
- Adds: configurable WIDTH, up/down direction, Gray-coded parallel load, wrap or saturate mode, sticky Overflow/Underflow with explicit clear, terminal-count strobe, binary readback.
- Used for pointer/sequence generation where single-bit-change outputs are needed, e.g. FIFO pointers and position encoders.

Parameters:
- WIDTH, 3, counter width in bits; must be ≥2.
- SATURATE, 0, 0 = wrap at the ends; 1 = hold at the end value.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- En  input  1  count enable.
- Dir  input  1  1 = count up, 0 = count down; sampled only when counting.
- Load  input  1  parallel load strobe.
- LoadGray  input  WIDTH  Gray-coded load value; decoded to binary internally.
- ClrFlags  input  1  clears Overflow and Underflow.
- Output  output  WIDTH  Gray code of the current count.
- Binary  output  WIDTH  current count in binary.
- Overflow  output  1  sticky; set on an up-count attempted from MAX.
- Underflow  output  1  sticky; set on a down-count attempted from 0.
- Terminal  output  1  combinational; 1 when En=1, Load=0 and the count is MAX (Dir=1) or 0 (Dir=0).

Behaviour:
- State is one binary register cnt[WIDTH-1:0], plus the Overflow and Underflow registers.
  - MAX = 2^WIDTH−1.
  - Binary = cnt.
  - Output = cnt ^ (cnt>>1), combinational from cnt. Output therefore changes in the same cycle as cnt, with no extra latency.
- Reset (sync, active-high):
  - cnt=0, Output=0, Binary=0, Overflow=0, Underflow=0.
  - Terminal is then driven only by the inputs.
  - Reset overrides every other input in that cycle.
  - Reset asserted mid-count has full effect at the next edge.
- Priority per rising edge: Reset > Load > En. For cnt:
  - Load=1: cnt ← gray2bin(LoadGray), where bin[WIDTH-1]=g[WIDTH-1] and bin[i]=bin[i+1]^g[i]. En and Dir are ignored. Load does not set either flag.
  - Load=0, En=1, Dir=1: if cnt≠MAX then cnt+1. At MAX: SATURATE=0 wraps to 0; SATURATE=1 holds MAX.
  - Load=0, En=1, Dir=0: if cnt≠0 then cnt−1. At 0: SATURATE=0 wraps to MAX; SATURATE=1 holds 0.
  - Load=0, En=0: cnt holds.
- Flags:
  - Overflow ← 1 on a count step taken with Load=0, En=1, Dir=1 from cnt=MAX, in both modes.
  - Underflow ← 1 on a count step with Load=0, En=1, Dir=0 from cnt=0.
  - Otherwise each flag holds, unless ClrFlags=1, which clears it to 0.
  - If a set condition and ClrFlags=1 occur in the same cycle, set wins and the flag becomes 1.
  - ClrFlags does not affect cnt.
- Terminal is a single-cycle pre-wrap indicator and can be used for cascading. It is not registered and has no reset value of its own.
- Arithmetic is modulo 2^WIDTH. There are no X states: every input combination is defined.

Decomposition:
- Package gray_pkg:
  - function bin2gray(WIDTH-generic);
  - function gray2bin(WIDTH-generic);
  - localparam-style constants MODE_WRAP=0, MODE_SAT=1.
- Sub-module gray_to_bin (WIDTH param, combinational prefix-XOR decoder):
  - decodes LoadGray;
  - reused later by FIFO pointer synchronisers.
- Counter control and flags stay in gray_counter_param.

Test Plan:
1. WIDTH=3, SATURATE=0: Reset, then En=1, Dir=1 for 9 cycles.
   - Output goes 000,001,011,010,110,111,101,100,000,001.
   - Overflow rises on the edge leaving 100 and then stays 1.
   - Terminal=1 only during the cycle where Output=100.
2. From cnt=0 (Output 000), Dir=0, En=1 for 2 cycles.
   - Output goes 100 then 101; Underflow=1; Overflow unchanged.
3. SATURATE=1, WIDTH=3:
   - At MAX with Dir=1, 3 cycles: Output stays 100 and Overflow=1.
   - At 0 with Dir=0: Output stays 000 and Underflow=1.
4. Load=1, LoadGray=110, En=1, Dir=0 in the same cycle.
   - Binary=100 and Output=110; the count step is ignored; no flag changes.
   - Next cycle with Load=0: Binary=011.
5. With Overflow=1, pulse ClrFlags in an idle cycle: Overflow=0.
   - Then with cnt=MAX, assert ClrFlags, En=1, Dir=1 together: Overflow=1 (set wins).
6. WIDTH=8, mid-count Reset at cnt=0x5A with En=1:
   - next edge: cnt=0, Output=0, both flags 0.
   - Exhaustively check Output==bin2gray(Binary) and that Hamming distance between successive Outputs is 1 during a full up sweep.
